ahb_slave_front: RTL and testbench

AHB_SLAVE_FRONT -- requirements
Module: ahb_slave_front

---
 rtl/ahb_apb_pkg.sv | 37 +++
 rtl/ahb_addr_check.sv | 21 ++
 rtl/ahb_slave_front.sv | 128 ++++++++++++
 tb/tb_ahb_slave_front.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared types for the AHB slave front end: HTRANS/HRESP encodings, FSM states
// and the request record handed to the APB controller.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_REQ,
    ST_RSP,
    ST_ERR1,
    ST_ERR2
  } state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } apb_req_t;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY complete as no-ops.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_addr_check.sv
// Combinational region decode: in_range is high for addresses in
// [ADDR_BASE, ADDR_BASE+ADDR_SIZE). Built only with AHB_ADDR_RANGE_CHECK_EN.
`ifdef AHB_ADDR_RANGE_CHECK_EN
module ahb_addr_check #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0001_0000
) (
  input  logic [31:0] addr,
  output logic        in_range
);

  // 33-bit compare so a region ending at 4 GiB does not wrap.
  localparam logic [32:0] REGION_LO = {1'b0, ADDR_BASE};
  localparam logic [32:0] REGION_HI = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

  always_comb begin
    in_range = ({1'b0, addr} >= REGION_LO) && ({1'b0, addr} < REGION_HI);
  end

endmodule
`endif

// File: rtl/ahb_slave_front.sv
// AHB-Lite slave front end: accepts one transfer, forwards it to the APB
// controller, waits for completion. Optional range check: AHB_ADDR_RANGE_CHECK_EN.
module ahb_slave_front
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        HRESETn,
  input  logic        HSELAHB,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_write,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  input  logic        rsp_err
);

  state_e      state;
  state_e      state_nxt;
  apb_req_t    req_q;
  logic [31:0] hrdata_q;
  logic        accept;
  logic        addr_ok;

`ifdef AHB_ADDR_RANGE_CHECK_EN
  ahb_addr_check #(
    .ADDR_BASE (ADDR_BASE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_addr_check (
    .addr     (HADDR),
    .in_range (addr_ok)
  );
`else
  logic unused_cfg;
  assign addr_ok    = 1'b1;
  assign unused_cfg = ^{ADDR_BASE, ADDR_SIZE};
`endif

  // HREADY is 1 in IDLE, so an IDLE-state accept is also the completion cycle of
  // the previous transfer, giving back-to-back pipelining for free.
  assign accept = (state == ST_IDLE) && HSELAHB && htrans_active(HTRANS);

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    HREADY    = 1'b0;
    HRESP     = HRESP_OKAY;
    req_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        HREADY = 1'b1;
        if (accept) begin
          state_nxt = addr_ok ? ST_DATA : ST_ERR1;
        end
      end
      ST_DATA: begin
        req_valid = 1'b1;
        state_nxt = req_ready ? ST_RSP : ST_REQ;
      end
      ST_REQ: begin
        req_valid = 1'b1;
        if (req_ready) begin
          state_nxt = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_valid) begin
          state_nxt = rsp_err ? ST_ERR1 : ST_IDLE;
        end
      end
      ST_ERR1: begin
        HRESP     = HRESP_ERROR;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP     = HRESP_ERROR;
        HREADY    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      req_q    <= '0;
      hrdata_q <= '0;
    end else begin
      if (accept) begin
        req_q.addr  <= HADDR;
        req_q.write <= HWRITE;
      end
      // Write data arrives in the first data-phase cycle only.
      if ((state == ST_DATA) && req_q.write) begin
        req_q.wdata <= HWDATA;
      end
      if ((state == ST_RSP) && rsp_valid && !rsp_err) begin
        hrdata_q <= rsp_rdata;
      end
    end
  end

  assign HRDATA    = hrdata_q;
  assign req_write = req_q.write;
  assign req_addr  = req_q.addr;
  assign req_wdata = req_q.wdata;

endmodule

// File: tb/tb_ahb_slave_front.sv
// Self-checking bench for ahb_slave_front: randomized transfers against a
// transaction-timeline model, plus directed scenarios with literal expectations.
module tb_ahb_slave_front;
  import ahb_apb_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SIZE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSELAHB, HWRITE, req_ready, rsp_valid, rsp_err;
  logic [31:0] HADDR, HWDATA, rsp_rdata;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA, req_addr, req_wdata;
  logic        HREADY, HRESP, req_valid, req_write;

  always #5 clk = ~clk;

  ahb_slave_front #(
    .ADDR_BASE (BASE),
    .ADDR_SIZE (SIZE)
  ) dut (
    .clk       (clk),
    .HRESETn   (HRESETn),
    .HSELAHB   (HSELAHB),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: what the slave must be presenting, tracked per transaction.
  logic [31:0] m_hrdata = '0, m_addr = '0, m_wdata = '0;
  logic        m_write = 1'b0;
  logic        e_hready, e_hresp, e_rv, e_write;
  logic [31:0] e_hrdata, e_addr, e_wdata;
  bit          chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("HREADY",    32'(HREADY),    32'(e_hready));
      chk("HRESP",     32'(HRESP),     32'(e_hresp));
      chk("req_valid", 32'(req_valid), 32'(e_rv));
      chk("HRDATA",    HRDATA,         e_hrdata);
      chk("req_addr",  req_addr,       e_addr);
      chk("req_write", 32'(req_write), 32'(e_write));
      chk("req_wdata", req_wdata,      e_wdata);
    end
  end

  int unsigned c_hrl = 0, c_rv = 0, c_resp = 0;
  always @(negedge clk) begin
    if (HRESETn) begin
      if (!HREADY)  c_hrl++;
      if (req_valid) c_rv++;
      if (HRESP)    c_resp++;
    end
  end

  function automatic bit in_range(input logic [31:0] a);
`ifdef AHB_ADDR_RANGE_CHECK_EN
    longint unsigned lo, hi;
    lo = longint'(BASE);
    hi = longint'(BASE) + longint'(SIZE);
    return (longint'(a) >= lo) && (longint'(a) < hi);
`else
    return (a == a);
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit hready, input bit hresp, input bit rv);
    e_hready = hready;
    e_hresp  = hresp;
    e_rv     = rv;
    e_hrdata = m_hrdata;
    e_addr   = m_addr;
    e_write  = m_write;
    e_wdata  = m_wdata;
  endtask

  task automatic junk();
    HSELAHB   = 1'($urandom);
    HTRANS    = 2'($urandom);
    HADDR     = $urandom;
    HWRITE    = 1'($urandom);
    HWDATA    = $urandom;
    req_ready = 1'($urandom);
    rsp_valid = 1'($urandom);
    rsp_err   = 1'($urandom);
    rsp_rdata = $urandom;
  endtask

  task automatic idle_cycle(input int unsigned sel);
    junk();
    case (sel)
      0:       HSELAHB = 1'b0;
      1:       begin HSELAHB = 1'b1; HTRANS = HTRANS_IDLE; end
      2:       begin HSELAHB = 1'b1; HTRANS = HTRANS_BUSY; end
      default: begin HSELAHB = 1'b0; HTRANS = HTRANS_NONSEQ; end
    endcase
    set_exp(1'b1, 1'b0, 1'b0);
    cyc();
  endtask

  task automatic err_tail();
    junk();
    set_exp(1'b0, 1'b1, 1'b0);
    cyc();
    // Master still presents a transfer during the second error cycle; it must be dropped.
    junk();
    HSELAHB = 1'b1;
    HTRANS  = HTRANS_NONSEQ;
    set_exp(1'b1, 1'b1, 1'b0);
    cyc();
  endtask

  // Called at the start of a cycle in which the slave shows HREADY=1 in IDLE.
  // dr: cycles req_ready is withheld; drsp: cycles in RSP before rsp_valid.
  task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int unsigned dr, input int unsigned drsp,
                         input bit err, input logic [31:0] rdata);
    bit ok;
    ok = in_range(addr);
    junk();
    HSELAHB = 1'b1;
    HTRANS  = 1'($urandom) ? HTRANS_NONSEQ : HTRANS_SEQ;
    HADDR   = addr;
    HWRITE  = wr;
    set_exp(1'b1, 1'b0, 1'b0);
    cyc();
    m_addr  = addr;
    m_write = wr;
    if (!ok) begin
      err_tail();
      return;
    end
    junk();
    HWDATA    = wdata;
    req_ready = (dr == 0);
    set_exp(1'b0, 1'b0, 1'b1);
    cyc();
    if (wr) m_wdata = wdata;
    for (int unsigned i = 1; i <= dr; i++) begin
      junk();
      req_ready = (i == dr);
      set_exp(1'b0, 1'b0, 1'b1);
      cyc();
    end
    for (int unsigned j = 0; j <= drsp; j++) begin
      junk();
      rsp_valid = (j == drsp);
      if (j == drsp) begin
        rsp_err   = err;
        rsp_rdata = rdata;
      end
      set_exp(1'b0, 1'b0, 1'b0);
      cyc();
    end
    if (err) err_tail();
    else     m_hrdata = rdata;
  endtask

  int unsigned s_hrl, s_rv, s_resp;
  task automatic snap();
    s_hrl  = c_hrl;
    s_rv   = c_rv;
    s_resp = c_resp;
  endtask

  initial begin
    HSELAHB = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;

    repeat (2) @(posedge clk);
    #2;
    chk("rst HREADY",    32'(HREADY),    32'd1);
    chk("rst HRESP",     32'(HRESP),     32'd0);
    chk("rst HRDATA",    HRDATA,         32'd0);
    chk("rst req_valid", 32'(req_valid), 32'd0);
    chk("rst req_addr",  req_addr,       32'd0);
    chk("rst req_wdata", req_wdata,      32'd0);
    cyc();
    HRESETn = 1'b1;
    chk_en  = 1'b1;

    // Write, zero-delay handshake: two wait states.
    snap();
    do_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0000_00A5);
    chk("r027 wait states", c_hrl - s_hrl, 32'd2);
    chk("r027 req_wdata",   req_wdata,     32'hDEAD_BEEF);
    chk("r027 HRESP",       32'(HRESP),    32'd0);
    chk("r027 HRDATA",      HRDATA,        32'h0000_00A5);

    // Read with req_ready delayed three cycles.
    snap();
    do_xfer(1'b0, 32'h0000_0020, 32'h0, 3, 0, 1'b0, 32'h1234_5678);
    chk("r028 req_valid cycles", c_rv - s_rv,  32'd4);
    chk("r028 wait states",      c_hrl - s_hrl, 32'd5);
    chk("r028 HRDATA",           HRDATA,        32'h1234_5678);
    chk("r028 HREADY",           32'(HREADY),   32'd1);
    chk("r028 req_wdata kept",   req_wdata,     32'hDEAD_BEEF);

    // Error response on a read.
    snap();
    do_xfer(1'b0, 32'h0000_0024, 32'h0, 0, 1, 1'b1, 32'hCAFE_F00D);
    chk("r029 HRESP cycles", c_resp - s_resp, 32'd2);
    chk("r029 wait states",  c_hrl - s_hrl,   32'd4);
    chk("r029 HRDATA held",  HRDATA,          32'h1234_5678);

    // No-op transfers.
    snap();
    idle_cycle(1);
    idle_cycle(2);
    idle_cycle(3);
    chk("r030 req_valid cycles", c_rv - s_rv,   32'd0);
    chk("r030 wait states",      c_hrl - s_hrl, 32'd0);

`ifdef AHB_ADDR_RANGE_CHECK_EN
    snap();
    do_xfer(1'b1, 32'h0002_0000, 32'h1111_2222, 0, 0, 1'b0, 32'h0);
    chk("r032 req_valid cycles", c_rv - s_rv,     32'd0);
    chk("r032 HRESP cycles",     c_resp - s_resp, 32'd2);
`endif

    for (int unsigned n = 0; n < 60; n++) begin
      logic [31:0] a;
      int unsigned gaps;
      gaps = $urandom_range(0, 2);
      for (int unsigned g = 0; g < gaps; g++) idle_cycle($urandom_range(0, 3));
`ifdef AHB_ADDR_RANGE_CHECK_EN
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h0000_FFFF));
`else
      a = $urandom;
`endif
      do_xfer(1'($urandom), a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0), $urandom);
    end

    // Reset asserted while the request is waiting for req_ready.
    HSELAHB = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h0000_0044; HWRITE = 1'b1;
    req_ready = 1'b0; rsp_valid = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0);
    cyc();
    m_addr  = 32'h0000_0044;
    m_write = 1'b1;
    junk();
    HWDATA = 32'h5555_AAAA; req_ready = 1'b0;
    set_exp(1'b0, 1'b0, 1'b1);
    cyc();
    m_wdata = 32'h5555_AAAA;
    junk();
    req_ready = 1'b0;
    chk("r031 req_valid before", 32'(req_valid), 32'd1);
    chk_en  = 1'b0;
    HRESETn = 1'b0;
    #1;
    chk("r031 req_valid", 32'(req_valid), 32'd0);
    chk("r031 HREADY",    32'(HREADY),    32'd1);
    chk("r031 HRESP",     32'(HRESP),     32'd0);
    chk("r031 HRDATA",    HRDATA,         32'd0);
    chk("r031 req_addr",  req_addr,       32'd0);
    chk("r031 req_write", 32'(req_write), 32'd0);
    chk("r031 req_wdata", req_wdata,      32'd0);
    req_ready = 1'b1;
    cyc();
    cyc();
    HRESETn  = 1'b1;
    m_hrdata = '0; m_addr = '0; m_wdata = '0; m_write = 1'b0;
    chk_en   = 1'b1;
    snap();
    for (int unsigned k = 0; k < 4; k++) idle_cycle(k);
    chk("r031 no request after release", c_rv - s_rv, 32'd0);
    do_xfer(1'b1, 32'h0000_0100, 32'h0BAD_F00D, 1, 2, 1'b0, 32'h7777_0001);
    chk("post-reset HRDATA", HRDATA, 32'h7777_0001);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
